// File: rtl/data_mem_responder_pkg.sv
// Shared memory-access definitions: size codes, responder FSM states, captured request.
// The future controller's lb/lh/lw/lbu/lhu/sb/sh/sw decode uses the same size codes.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sign_ext;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Reserved size, or a half/word that does not sit on its natural boundary.
    function automatic logic mem_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b11)
            || (size == SZ_HALF && addr_lo[0])
            || (size == SZ_WORD && addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the datapath (master) and the data memory (slave).
interface data_mem_responder_if;
    import mem_pkg::*;

    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ready, err
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ready, err
    );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering: write enables and merged store word, plus extended load value.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rext
);

    logic [31:0] wrep;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Replicating the right-justified data lets every lane pick its byte in place.
    always_comb begin
        be   = 4'b0000;
        wrep = wdata;
        case (size)
            SZ_BYTE: begin
                be   = 4'b0001 << addr_lo;
                wrep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign wword[8*k +: 8] = be[k] ? wrep[8*k +: 8] : rword[8*k +: 8];
    end

    assign rbyte = rword[{addr_lo, 3'b000} +: 8];
    assign rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        case (size)
            SZ_BYTE: rext = {{24{sign_ext & rbyte[7]}}, rbyte};
            SZ_HALF: rext = {{16{sign_ext & rhalf[15]}}, rhalf};
            default: rext = rword;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with byte/half/word access, wait states and req/ready handshake.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    mem_req_t    req_q, req_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    mem_req_t         live, acc;
    logic [IDX_W-1:0] acc_idx;
    logic             acc_err, enter_resp, mem_we;
    logic [3:0]       be;
    logic [31:0]      wword, rext;
    logic             unused_addr_hi;

    assign live = {bus.we, bus.size, bus.sign_ext, bus.addr, bus.wdata};
    // With no wait states the access completes on the accepting edge, before capture lands.
    assign acc            = (state_q == IDLE) ? live : req_q;
    assign acc_idx        = acc.addr[IDX_W+1:2];
    assign acc_err        = mem_bad_access(acc.size, acc.addr[1:0]);
    assign unused_addr_hi = ^{acc.addr[31:IDX_W+2], be};

    mem_lane_align u_align (
        .size     (acc.size),
        .addr_lo  (acc.addr[1:0]),
        .sign_ext (acc.sign_ext),
        .wdata    (acc.wdata),
        .rword    (mem_q[acc_idx]),
        .be       (be),
        .wword    (wword),
        .rext     (rext)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    req_d = live;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        enter_resp = (state_d == RESP);
        ready_d    = enter_resp;
        err_d      = enter_resp & acc_err;
        mem_we     = enter_resp & acc.we & ~acc_err;
        rdata_d    = (enter_resp && !acc.we && !acc_err) ? rext : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a reset edge still cancels an in-flight store.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem_q[acc_idx] <= wword;
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized check of three responders (0, 1 and 3 wait states) against a byte-array model.
module tb_data_mem_responder;
    import mem_pkg::*;

    localparam int NDUT  = 3;
    localparam int DEPTH = 256;
    localparam int SPAN  = DEPTH * 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       req_v, we_v, sx_v, ready_v, err_v;
    logic [NDUT-1:0][1:0]  size_v;
    logic [NDUT-1:0][31:0] addr_v, wdata_v, rdata_v;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int WS = (g == 0) ? 0 : (g == 1) ? 1 : 3;
        data_mem_responder_if bus ();
        assign bus.req      = req_v[g];
        assign bus.we       = we_v[g];
        assign bus.size     = size_v[g];
        assign bus.sign_ext = sx_v[g];
        assign bus.addr     = addr_v[g];
        assign bus.wdata    = wdata_v[g];
        assign ready_v[g]   = bus.ready;
        assign err_v[g]     = bus.err;
        assign rdata_v[g]   = bus.rdata;
        data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mdl [NDUT][SPAN];
    logic [31:0] rd_exp [NDUT];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // One handshake on DUT d; model updated from the access rules, DUT checked at ready.
    task automatic access(input int d, input bit we, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold);
        bit          bad, seen;
        int          nb, lat, base;
        logic [31:0] v;
        bad  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        nb   = 1 << sz;
        base = int'(a % SPAN);
        if (!bad) begin
            if (we) begin
                for (int i = 0; i < nb; i++) mdl[d][base+i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[d][base+i];
                if (sx && nb < 4 && v[8*nb-1])
                    for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
                rd_exp[d] = v;
            end
        end
        req_v[d] = 1'b1; we_v[d] = we; size_v[d] = sz; sx_v[d] = sx;
        addr_v[d] = a; wdata_v[d] = wd;
        seen = 1'b0; lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (ready_v[d]) begin
                seen = 1'b1; lat = n;
            end else if (!hold) begin
                we_v[d] = 1'($urandom()); size_v[d] = 2'($urandom()); sx_v[d] = 1'($urandom());
                addr_v[d] = $urandom(); wdata_v[d] = $urandom();
            end
        end
        chk($sformatf("lat d%0d a=%h", d, a), 32'(lat), 32'(ws_of(d) + 1));
        if (seen) begin
            chk($sformatf("err d%0d a=%h sz=%0d", d, a, sz), 32'(err_v[d]), 32'(bad));
            chk($sformatf("rdata d%0d a=%h sz=%0d we=%0d", d, a, sz, we), rdata_v[d], rd_exp[d]);
        end
        if (!hold) req_v[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("ready_drop d%0d", d), 32'(ready_v[d]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;
        rst = 1'b1;
        req_v = '0; we_v = '0; sx_v = '0; size_v = '0; addr_v = '0; wdata_v = '0;
        for (int d = 0; d < NDUT; d++) rd_exp[d] = 32'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_ready d%0d", d), 32'(ready_v[d]), 32'd0);
            chk($sformatf("rst_err d%0d", d), 32'(err_v[d]), 32'd0);
            chk($sformatf("rst_rdata d%0d", d), rdata_v[d], 32'd0);
        end
        rst = 1'b0;

        for (int d = 0; d < NDUT; d++)
            for (int w = 0; w < DEPTH; w++) access(d, 1'b1, SZ_WORD, 1'b0, 32'(w * 4), $urandom(), 1'b0);

        for (int d = 0; d < NDUT; d++) begin
            access(d, 1, SZ_WORD, 0, 32'h10, 32'h12345678, 0);
            access(d, 0, SZ_WORD, 0, 32'h10, 32'h0, 0);
            chk($sformatf("word10 d%0d", d), rdata_v[d], 32'h12345678);
            access(d, 1, SZ_BYTE, 0, 32'h13, 32'h000000AB, 0);
            access(d, 0, SZ_WORD, 1, 32'h10, 32'h0, 0);
            chk($sformatf("byte_merge d%0d", d), rdata_v[d], 32'hAB345678);
            access(d, 0, SZ_BYTE, 1, 32'h13, 32'h0, 0);
            access(d, 0, SZ_BYTE, 0, 32'h13, 32'h0, 0);
            access(d, 1, SZ_HALF, 0, 32'h22, 32'h00008001, 0);
            access(d, 0, SZ_HALF, 1, 32'h22, 32'h0, 0);
            chk($sformatf("half_sx d%0d", d), rdata_v[d], 32'hFFFF8001);
            access(d, 0, SZ_HALF, 0, 32'h22, 32'h0, 0);
            access(d, 0, SZ_WORD, 0, 32'h20, 32'h0, 0);
            access(d, 1, SZ_WORD, 0, 32'h11, 32'hFFFFFFFF, 0);
            access(d, 0, SZ_HALF, 1, 32'h23, 32'h0, 0);
            access(d, 1, 2'b11, 0, 32'h10, 32'h0, 0);
            access(d, 0, 2'b11, 1, 32'h10, 32'h0, 0);
            access(d, 0, SZ_WORD, 0, 32'h10, 32'h0, 0);
            chk($sformatf("err_nowrite d%0d", d), rdata_v[d], 32'hAB345678);
            access(d, 1, SZ_WORD, 0, 32'h00000404, 32'hCAFE0000 + 32'(d), 0);
            access(d, 0, SZ_WORD, 0, 32'h00000004, 32'h0, 0);
            for (int k = 0; k < 4; k++) access(d, 0, SZ_WORD, 0, 32'h10, 32'h0, (k < 3));
        end

        for (int d = 0; d < NDUT; d++) begin
            repeat (150) begin
                r = $urandom_range(0, 9);
                sz = (r < 3) ? SZ_BYTE : (r < 6) ? SZ_HALF : (r < 9) ? SZ_WORD : 2'b11;
                a = $urandom();
                if ($urandom_range(0, 7) != 0) begin
                    if (sz == SZ_HALF) a[0] = 1'b0;
                    if (sz == SZ_WORD) a[1:0] = 2'b00;
                end
                access(d, 1'($urandom()), sz, 1'($urandom()), a, $urandom(), 1'b0);
            end
        end

        // Store abandoned by reset while waiting.
        req_v[2] = 1'b1; we_v[2] = 1'b1; size_v[2] = SZ_WORD; sx_v[2] = 1'b0;
        addr_v[2] = 32'h30; wdata_v[2] = 32'hDEADBEEF;
        @(negedge clk);
        chk("midrst_pre_ready", 32'(ready_v[2]), 32'd0);
        rst = 1'b1;
        req_v[2] = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_ready", 32'(ready_v[2]), 32'd0);
        end
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("postrst_rdata d%0d", d), rdata_v[d], 32'd0);
            chk($sformatf("postrst_ready d%0d", d), 32'(ready_v[d]), 32'd0);
            chk($sformatf("postrst_err d%0d", d), 32'(err_v[d]), 32'd0);
            rd_exp[d] = 32'd0;
        end
        access(2, 0, SZ_WORD, 0, 32'h30, 32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
